// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared register addresses, STATUS bit indices, serialiser
//               state encoding and divider helper for the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  // Register map on the 2-bit Wishbone address
  localparam logic [1:0] c_adr_data   = 2'd0;
  localparam logic [1:0] c_adr_status = 2'd1;
  localparam logic [1:0] c_adr_div_lo = 2'd2;
  localparam logic [1:0] c_adr_div_hi = 2'd3;

  // STATUS register bit positions
  localparam int c_stat_full  = 0;
  localparam int c_stat_empty = 1;
  localparam int c_stat_busy  = 2;
  localparam int c_stat_ovf   = 3;

  // Serialiser states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // A divider below 2 cannot form a sensible bit period, so clamp it.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous FIFO with extra pointer bit to tell full from
//               empty. Writes to a full FIFO and reads from an empty one are
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_ptr_one = (c_aw+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = wr_en & ~full;
  assign w_pop  = rd_en & ~empty;
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                  (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign count  = r_wr_ptr - r_rd_ptr;
  assign dout   = r_mem[r_rd_ptr[c_aw-1:0]];

  // Pointer update; reset discards any queued contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Storage array; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : Wishbone-classic 8N1 UART transmitter with TX FIFO,
//               programmable 16-bit baud divider and idle interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic       uart_clk_i,
  input  logic       uart_rst_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       uart_tx_o,
  output logic       uart_irq_o
);

  localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

  tx_state_t          r_state;
  tx_state_t          w_state_next;
  logic               r_ack;
  logic [7:0]         r_dat;
  logic [15:0]        r_div;
  logic               r_ovf;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic [15:0]        r_timer;
  logic [15:0]        r_div_lat;
  logic               r_tx;

  logic               w_req;
  logic               w_wr;
  logic               w_rd;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [c_cnt_w-1:0] w_fifo_count;
  logic [7:0]         w_fifo_dout;
  logic [4:0]         w_count_ext;
  logic [3:0]         w_count_sat;
  logic [7:0]         w_status;
  logic [7:0]         w_rdata;
  logic [15:0]        w_div_eff;
  logic               w_bit_end;
  logic               w_tx_next;

  // A new request is only accepted while ack is low, giving one ack per two cycles
  assign w_req  = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr   = w_req & wb_we_i;
  assign w_rd   = w_req & ~wb_we_i;
  assign w_push = w_wr & (wb_adr_i == c_adr_data);

  assign w_count_ext = 5'(w_fifo_count);
  assign w_count_sat = (w_count_ext > 5'd15) ? 4'hF : w_count_ext[3:0];

  always_comb begin
    w_status               = 8'h00;
    w_status[c_stat_full]  = w_fifo_full;
    w_status[c_stat_empty] = w_fifo_empty;
    w_status[c_stat_busy]  = (r_state != S_IDLE);
    w_status[c_stat_ovf]   = r_ovf;
    w_status[7:4]          = w_count_sat;
  end

  assign w_div_eff = eff_div(r_div);
  assign w_bit_end = (r_timer == 16'd0);

  assign wb_ack_o   = r_ack;
  assign wb_dat_o   = r_dat;
  assign uart_tx_o  = r_tx;
  assign uart_irq_o = w_fifo_empty & (r_state == S_IDLE);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (uart_clk_i),
    .rst_n (uart_rst_i),
    .wr_en (w_push),
    .din   (wb_dat_i),
    .rd_en (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // Read-data multiplexer over the register map
  always_comb begin
    w_rdata = 8'h00;
    case (wb_adr_i)
      c_adr_status: w_rdata = w_status;
      c_adr_div_lo: w_rdata = r_div[7:0];
      c_adr_div_hi: w_rdata = r_div[15:8];
      default:      w_rdata = 8'h00;
    endcase
  end

  // Registered acknowledge and read data
  always_ff @(posedge uart_clk_i or negedge uart_rst_i) begin
    if (!uart_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 8'h00;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 8'h00;
    end
  end

  // Divider and sticky overflow; an overflowing push beats a clearing STATUS read
  always_ff @(posedge uart_clk_i or negedge uart_rst_i) begin
    if (!uart_rst_i) begin
      r_div <= 16'(DEFAULT_DIV);
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && wb_adr_i == c_adr_div_lo) r_div[7:0]  <= wb_dat_i;
      if (w_wr && wb_adr_i == c_adr_div_hi) r_div[15:8] <= wb_dat_i;
      if (w_push && w_fifo_full)
        r_ovf <= 1'b1;
      else if (w_rd && wb_adr_i == c_adr_status)
        r_ovf <= 1'b0;
    end
  end

  // Serialiser state register
  always_ff @(posedge uart_clk_i or negedge uart_rst_i) begin
    if (!uart_rst_i) r_state <= S_IDLE;
    else             r_state <= w_state_next;
  end

  // Serialiser next state, FIFO pop and line level for the current state
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx_next    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
        if (w_bit_end && r_bit_idx == 3'd7) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Shift register, bit index and bit timer; divider latched at each frame start
  always_ff @(posedge uart_clk_i or negedge uart_rst_i) begin
    if (!uart_rst_i) begin
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_timer   <= 16'd0;
      r_div_lat <= 16'd2;
    end else if (w_pop) begin
      r_shift   <= w_fifo_dout;
      r_bit_idx <= 3'd0;
      r_timer   <= w_div_eff - 16'd1;
      r_div_lat <= w_div_eff;
    end else if (r_state != S_IDLE) begin
      if (w_bit_end) begin
        r_timer <= r_div_lat - 16'd1;
        if (r_state == S_DATA) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else begin
        r_timer <= r_timer - 16'd1;
      end
    end
  end

  // Line driver register keeps the serial output glitch-free
  always_ff @(posedge uart_clk_i or negedge uart_rst_i) begin
    if (!uart_rst_i) r_tx <= 1'b1;
    else             r_tx <= w_tx_next;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx: register vectors table plus
//               directed serial-line sequences against hand-built waveforms.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_DLO  = 2'd2;
  localparam logic [1:0] A_DHI  = 2'd3;

  logic       clk;
  logic       rst_n;
  logic       cyc;
  logic       stb;
  logic       we;
  logic [1:0] adr;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       ack;
  logic       tx;
  logic       irq;

  int n_pass  = 0;
  int n_total = 0;

  logic cap_q[$];
  logic irq_q[$];
  logic exp_q[$];

  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];

  uart_tx #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (434)
  ) dut (
    .uart_clk_i (clk),
    .uart_rst_i (rst_n),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_i),
    .wb_dat_o   (dat_o),
    .wb_ack_o   (ack),
    .uart_tx_o  (tx),
    .uart_irq_o (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                      output logic [7:0] rd);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    @(posedge clk); #1;
    if (ack !== 1'b1) begin
      n_total++;
      $display("FAIL ack_timeout: got %b expected 1", ack);
    end
    rd  = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] unused;
    xfer(1'b1, a, d, unused);
  endtask

  task automatic add_frame(input logic [7:0] b, input int div);
    for (int k = 0; k < 10; k++) begin
      logic v;
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = 1'b1;
      else             v = b[k-1];
      for (int j = 0; j < div; j++) exp_q.push_back(v);
    end
  endtask

  // Waits (bounded) for the line to go low, then records n samples, one per clock
  task automatic capture(input int n, output int waited);
    cap_q.delete();
    irq_q.delete();
    waited = 0;
    while (tx !== 1'b0 && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (tx !== 1'b0) begin
      n_total++;
      $display("FAIL capture_timeout: got line %b expected 0 within 3000 clks", tx);
      return;
    end
    for (int i = 0; i < n; i++) begin
      cap_q.push_back(tx);
      irq_q.push_back(irq);
      if (i < n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic check_wave(input string name);
    int bad = -1;
    n_total++;
    if (cap_q.size() != exp_q.size()) begin
      $display("FAIL %s: got %0d samples expected %0d", name, cap_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < cap_q.size(); i++)
        if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
      if (bad < 0) n_pass++;
      else $display("FAIL %s: sample %0d got %b expected %b", name, bad, cap_q[bad], exp_q[bad]);
    end
    exp_q.delete();
  endtask

  task automatic idle_window(input string name, input int cycles);
    int lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
    end
    check(name, lows, 0);
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] s1;
    logic [7:0] s2;
    int         w;
    int         acks;

    tbl[0]  = '{1'b0, A_STAT, 8'h00, 8'h02};
    tbl[1]  = '{1'b0, A_DATA, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, A_DLO,  8'h00, 8'hB2};
    tbl[3]  = '{1'b0, A_DHI,  8'h00, 8'h01};
    tbl[4]  = '{1'b1, A_DLO,  8'h34, 8'h00};
    tbl[5]  = '{1'b0, A_DLO,  8'h00, 8'h34};
    tbl[6]  = '{1'b1, A_DHI,  8'h12, 8'h00};
    tbl[7]  = '{1'b0, A_DHI,  8'h00, 8'h12};
    tbl[8]  = '{1'b1, A_DHI,  8'h00, 8'h00};
    tbl[9]  = '{1'b1, A_DLO,  8'h04, 8'h00};
    tbl[10] = '{1'b0, A_DLO,  8'h00, 8'h04};
    tbl[11] = '{1'b0, A_STAT, 8'h00, 8'h02};

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; dat_i = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_tx",  tx,    1);
    check("rst_ack", ack,   0);
    check("rst_dat", dat_o, 0);
    check("rst_irq", irq,   1);

    // Register map vectors
    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i].we, tbl[i].adr, tbl[i].wdata, rd);
      if (!tbl[i].we) check($sformatf("reg_vec%0d", i), rd, tbl[i].exp);
    end

    // Held request: ack pulses one cycle, at most every other cycle
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("ack_spacing", acks, 2);

    // Single frame 0x55 at DIV=4: latency, waveform, interrupt
    wr(A_DATA, 8'h55);
    capture(40, w);
    check("start_latency", w, 2);
    add_frame(8'h55, 4);
    check_wave("frame_55");
    check("irq_busy", irq_q.size() == 40 ? int'(irq_q[38]) : -1, 0);
    check("irq_done", irq, 1);

    // Overflow: ten quick writes, one goes straight to the serialiser, one is dropped
    fork
      begin
        for (int i = 0; i < 10; i++) wr(A_DATA, 8'h10 + 8'(i));
        xfer(1'b0, A_STAT, 8'h00, s1);
        xfer(1'b0, A_STAT, 8'h00, s2);
      end
      begin
        capture(360, w);
      end
    join
    check("status_ovf", s1, 8'h8D);
    check("status_clr", s2, 8'h85);
    for (int i = 0; i < 9; i++) add_frame(8'h10 + 8'(i), 4);
    check_wave("nine_frames");
    idle_window("no_tenth_frame", 60);
    check("irq_after_burst", irq, 1);

    // Back-to-back frames, no idle gap
    fork
      begin
        wr(A_DATA, 8'hA0);
        wr(A_DATA, 8'h0F);
      end
      begin
        capture(80, w);
      end
    join
    add_frame(8'hA0, 4);
    add_frame(8'h0F, 4);
    check_wave("back_to_back");
    @(posedge clk); #1;
    check("b2b_idle_tx",  tx,  1);
    check("b2b_idle_irq", irq, 1);

    // Reset in the middle of the data bits
    wr(A_DATA, 8'h00);
    wr(A_DATA, 8'h77);
    wr(A_DATA, 8'h88);
    repeat (11) begin
      @(posedge clk); #1;
    end
    check("pre_reset_low", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx", tx,  1);
    check("async_ack", ack, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    xfer(1'b0, A_STAT, 8'h00, rd);
    check("post_reset_status", rd, 8'h02);
    idle_window("post_reset_quiet", 100);

    // Divider change mid-frame takes effect on the next frame
    wr(A_DHI, 8'h00);
    wr(A_DLO, 8'h04);
    fork
      begin
        wr(A_DATA, 8'h00);
        wr(A_DLO,  8'h08);
        wr(A_DATA, 8'hC3);
      end
      begin
        capture(120, w);
      end
    join
    add_frame(8'h00, 4);
    add_frame(8'hC3, 8);
    check_wave("div_change");

    // DIV of 1 and 0 both behave as 2
    wr(A_DLO, 8'h01);
    fork
      wr(A_DATA, 8'h5A);
      capture(20, w);
    join
    add_frame(8'h5A, 2);
    check_wave("div_one");
    wr(A_DLO, 8'h00);
    fork
      wr(A_DATA, 8'hA5);
      capture(20, w);
    join
    add_frame(8'hA5, 2);
    check_wave("div_zero");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
